// File: rtl/pdm_tx_model.sv
// PDM transmitter model: 4-deep PCM FIFO feeding a first-order sigma-delta modulator
// clocked by bit ticks recovered from an externally supplied, asynchronous mic_clk.
module pdm_tx_model (
    input  logic        clk,
    input  logic        rst,
    input  logic        mic_clk,
    input  logic        channel,
    input  logic        enable,
    input  logic [7:0]  interp_num,
    input  logic [15:0] pcm_in,
    input  logic        pcm_valid,
    output logic        pcm_ready,
    input  logic        underrun_clr,
    output logic        pdm_out,
    output logic        underrun,
    output logic [2:0]  fifo_level
);

    // sync_pipe[0] = s1, [1] = s2, [2] = s3
    logic [2:0]       sync_pipe;
    logic             bit_tick;
    logic [3:0][15:0] fifo_mem;
    logic [1:0]       wr_ptr, rd_ptr;
    logic [15:0]      cur;
    logic [15:0]      acc;
    logic [7:0]       hold_cnt;
    logic             primed;
    logic             push, pop, load;
    logic [16:0]      u, sum;

    assign bit_tick  = channel ? (sync_pipe[1] & ~sync_pipe[2])
                               : (~sync_pipe[1] & sync_pipe[2]);
    assign pcm_ready = (fifo_level < 3'd4);
    assign push      = pcm_valid & pcm_ready;

    // primed drops while disabled so the first enabled tick always loads a sample
    assign load      = enable & bit_tick & (~primed | (hold_cnt == interp_num));
    assign pop       = load & (fifo_level != 3'd0);

    // cur + 32768 is the offset-binary form of cur: flip the sign bit
    assign u         = {1'b0, cur ^ 16'h8000};
    assign sum       = {1'b0, acc} + u;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_pipe  <= '0;
            fifo_mem   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            cur        <= '0;
            acc        <= '0;
            hold_cnt   <= '0;
            primed     <= 1'b0;
            pdm_out    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], mic_clk};

            if (push) begin
                fifo_mem[wr_ptr] <= pcm_in;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                cur    <= fifo_mem[rd_ptr];
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_level <= fifo_level + {2'b00, push} - {2'b00, pop};

            if (!enable) begin
                pdm_out  <= 1'b0;
                acc      <= '0;
                hold_cnt <= '0;
                primed   <= 1'b0;
            end else if (bit_tick) begin
                pdm_out <= sum[16];
                acc     <= sum[15:0];
                if (load) begin
                    hold_cnt <= '0;
                    primed   <= 1'b1;
                end else begin
                    // natural 8-bit wrap covers interp_num lowered below hold_cnt
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end

            if (load && fifo_level == 3'd0)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_tx_model.sv
// Randomized and directed bench for pdm_tx_model against a queue/integer reference model.
module tb_pdm_tx_model;

    logic        clk = 1'b0;
    logic        rst, mic_clk, channel, enable;
    logic [7:0]  interp_num;
    logic [15:0] pcm_in;
    logic        pcm_valid, pcm_ready, underrun_clr, pdm_out, underrun;
    logic [2:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_q[$];
    int m_cur, m_acc, m_hold, m_interp;
    bit m_pdm, m_und, m_primed, m_en;

    pdm_tx_model dut (
        .clk(clk), .rst(rst), .mic_clk(mic_clk), .channel(channel), .enable(enable),
        .interp_num(interp_num), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready), .underrun_clr(underrun_clr), .pdm_out(pdm_out),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    always #10 clk = ~clk;

    function automatic void model_reset();
        m_q.delete();
        m_cur = 0; m_acc = 0; m_hold = 0;
        m_pdm = 0; m_und = 0; m_primed = 0;
    endfunction

    // One clk of behaviour, from the rules: sigma-delta step, hold/reload, sticky underrun, FIFO push.
    function automatic void model_cycle(bit tick, bit clr, bit push_req, int data);
        bit ready  = (m_q.size() < 4);
        bit set_ev = 0;
        int s;
        if (!m_en) begin
            m_pdm = 0; m_acc = 0; m_hold = 0; m_primed = 0;
        end else if (tick) begin
            s     = m_acc + m_cur + 32768;
            m_pdm = (s >= 65536);
            m_acc = s % 65536;
            if (!m_primed || m_hold == m_interp) begin
                m_hold = 0; m_primed = 1;
                if (m_q.size() > 0) m_cur = m_q.pop_front();
                else set_ev = 1;
            end else begin
                m_hold = (m_hold + 1) % 256;
            end
        end
        if (set_ev) m_und = 1;
        else if (clr) m_und = 0;
        if (push_req && ready) m_q.push_back(data);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mic_clk = 1'b0; enable = 1'b0; m_en = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_enable(input bit v);
        @(negedge clk);
        enable = v; m_en = v;
        @(negedge clk);
        model_cycle(0, 0, 0, 0);
    endtask

    task automatic set_interp(input int v);
        @(negedge clk);
        interp_num = v[7:0]; m_interp = v;
    endtask

    task automatic push(input logic [15:0] d);
        @(negedge clk);
        pcm_valid = 1'b1; pcm_in = d;
        checks++;
        if (pcm_ready !== 1'(m_q.size() < 4)) begin
            failures++;
            $display("FAIL push_ready got=%0b want=%0b", pcm_ready, m_q.size() < 4);
        end
        @(negedge clk);
        pcm_valid = 1'b0;
        model_cycle(0, 0, 1, int'($signed(d)));
        checks++;
        if (fifo_level !== 3'(m_q.size())) begin
            failures++;
            $display("FAIL push_level got=%0d want=%0d", fifo_level, m_q.size());
        end
    endtask

    // Drive mic_clk to val; any tick is registered at the 3rd clk edge after the change,
    // and clr/push are presented so they coincide with that edge.
    task automatic mic_edge(input bit val, input bit clr = 0, input bit pv = 0,
                            input logic [15:0] d = '0);
        bit tick;
        tick = (val != mic_clk) && (channel ? val : !val);
        @(negedge clk);
        mic_clk = val;
        @(negedge clk);
        checks++;
        if (pdm_out !== m_pdm) begin
            failures++;
            $display("FAIL edge_hold pdm_out got=%0b want=%0b", pdm_out, m_pdm);
        end
        @(negedge clk);
        checks++;
        if (pdm_out !== m_pdm) begin
            failures++;
            $display("FAIL edge_early pdm_out got=%0b want=%0b", pdm_out, m_pdm);
        end
        underrun_clr = clr; pcm_valid = pv; pcm_in = d;
        @(negedge clk);
        underrun_clr = 1'b0; pcm_valid = 1'b0;
        model_cycle(tick, clr, pv, int'($signed(d)));
        checks++;
        if (pdm_out !== m_pdm || underrun !== m_und || fifo_level !== 3'(m_q.size())
            || pcm_ready !== 1'(m_q.size() < 4)) begin
            failures++;
            $display("FAIL edge_update got pdm=%0b und=%0b lvl=%0d rdy=%0b want pdm=%0b und=%0b lvl=%0d",
                     pdm_out, underrun, fifo_level, pcm_ready, m_pdm, m_und, m_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pdm_out !== 1'b0 || fifo_level !== 3'd0 || pcm_ready !== 1'b1 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got pdm=%0b lvl=%0d rdy=%0b und=%0b want 0 0 1 0",
                     pdm_out, fifo_level, pcm_ready, underrun);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        channel = 1'b1;
        set_interp(0);
        repeat (4) push(16'h0000);
        set_enable(1);
        for (int k = 0; k < 6; k++) begin
            mic_edge(1);
            checks++;
            if (pdm_out !== 1'(k % 2)) begin
                failures++;
                $display("FAIL alternate_bit%0d got=%0b want=%0b", k, pdm_out, k % 2);
            end
            mic_edge(0);
        end
    endtask

    task automatic test_extremes();
        do_reset();
        channel = 1'b1;
        set_interp(3);
        push(16'h8000);
        push(16'h7fff);
        set_enable(1);
        repeat (14) begin mic_edge(1); mic_edge(0); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        channel = 1'b1;
        for (int i = 0; i < 5; i++) push(16'(i * 1000 + 7));
        checks++;
        if (fifo_level !== 3'd4 || pcm_ready !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full got lvl=%0d rdy=%0b want 4 0", fifo_level, pcm_ready);
        end
        set_enable(1);
        mic_edge(1);
        checks++;
        if (fifo_level !== 3'd3 || pcm_ready !== 1'b1) begin
            failures++;
            $display("FAIL fifo_after_pop got lvl=%0d rdy=%0b want 3 1", fifo_level, pcm_ready);
        end
        mic_edge(0);
    endtask

    task automatic test_channel_left();
        do_reset();
        channel = 1'b0;
        set_interp(0);
        repeat (4) push(16'h0000);
        set_enable(1);
        repeat (6) begin mic_edge(1); mic_edge(0); end
    endtask

    task automatic test_underrun();
        do_reset();
        channel = 1'b1;
        set_interp(0);
        set_enable(1);
        mic_edge(1);
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_set got=%0b want=1", underrun);
        end
        mic_edge(0);
        @(negedge clk); underrun_clr = 1'b1;
        @(negedge clk); underrun_clr = 1'b0;
        model_cycle(0, 1, 0, 0);
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL underrun_clr got=%0b want=0", underrun);
        end
        mic_edge(1, 1);
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_set_wins got=%0b want=1", underrun);
        end
        mic_edge(0);
    endtask

    task automatic test_interp_wrap();
        do_reset();
        channel = 1'b1;
        set_interp(5);
        repeat (4) push(16'($urandom));
        set_enable(1);
        repeat (4) begin mic_edge(1); mic_edge(0); end
        set_interp(1);
        for (int i = 0; i < 260; i++) begin
            mic_edge(1, 0, (i % 40) == 0, 16'($urandom));
            mic_edge(0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        channel = 1'b1;
        set_interp(0);
        set_enable(1);
        mic_edge(1);
        repeat (4) push(16'($urandom));
        mic_edge(0);
        mic_edge(1);
        channel = 1'b0;
        // falling edge whose tick lands exactly on the reset cycle
        @(negedge clk); mic_clk = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        checks++;
        if (fifo_level !== 3'd0 || pdm_out !== 1'b0 || underrun !== 1'b0 || pcm_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got lvl=%0d pdm=%0b und=%0b rdy=%0b want 0 0 0 1",
                     fifo_level, pdm_out, underrun, pcm_ready);
        end
        push(16'h4000);
        repeat (4) begin mic_edge(1); mic_edge(0); end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        channel = 1'b1;
        set_interp(1);
        set_enable(1);
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 19);
            if (r < 5) push(16'($urandom));
            else if (r < 17) mic_edge(!mic_clk, $urandom_range(0, 7) == 0,
                                      $urandom_range(0, 2) == 0, 16'($urandom));
            else if (r == 17) set_interp($urandom_range(0, 3));
            else if (r == 18) set_enable(!m_en);
            else begin @(negedge clk); channel = !channel; end
        end
    endtask

    initial begin
        rst = 1'b0; mic_clk = 1'b0; channel = 1'b1; enable = 1'b0;
        interp_num = '0; pcm_in = '0; pcm_valid = 1'b0; underrun_clr = 1'b0;
        m_en = 0; m_interp = 0;
        model_reset();
        test_reset();
        test_alternate();
        test_extremes();
        test_fifo_full();
        test_channel_left();
        test_underrun();
        test_interp_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
